axi4lite_tohost_splitter: RTL and testbench
===========================================

// Module: axi4lite_tohost_splitter
// PURPOSE
//  Sits between the core's AXI4-Lite data bus and the data SRAM. Forwards all traffic to the SRAM except
//  accesses to the tohost word, which it terminates locally. Latches the tohost code and exposes
//  done/pass status to the test harness.
//  Drop-in replacement for ad-hoc bus snooping in unit-level core benches.
// PARAMETERS
//  ADDR_W        32            address width, both ports
//  TOHOST_ADDR   32'h00006000  word address decoded locally; exact match on awaddr/araddr
//  SUCCESS_CODE  32'd1         tohost value meaning pass
// PORTS (s_ = upstream slave port from core, m_ = downstream master port to SRAM; payloads per AXI4-Lite)
//  clock         in   1   single clock, all state on rising edge
//  reset         in   1   asynchronous, active-high
//  s_aw*         in   1/ADDR_W/3/4  awvalid/awaddr/awprot/awcache; s_awready out 1
//  s_w*          in   1/32/4        wvalid/wdata/wstrb; s_wready out 1
//  s_b*          out  1/2           bvalid/bresp; s_bready in 1
//  s_ar*         in   1/ADDR_W/3/4  arvalid/araddr/arprot/arcache; s_arready out 1
//  s_r*          out  1/2/32        rvalid/rresp/rdata; s_rready in 1
//  m_aw*,m_w*,m_b*,m_ar*,m_r*       mirror of s_* with directions reversed, to SRAM
//  tohost_valid  out  1   one-cycle pulse when a tohost write completes (B handshake)
//  tohost_data   out  32  last value written to tohost
//  done          out  1   sticky; set by any nonzero tohost write
//  pass          out  1   done && tohost_data == SUCCESS_CODE
// BEHAVIOUR
//  Reset: all valid/ready outputs 0, both FSMs IDLE, tohost_data=0, done=0, tohost_valid=0.
//  Independent write and read FSMs; at most one write and one read outstanding.
//  Write FSM: WIDLE -> WFWD | WLOC -> WMRSP | WLRSP -> WIDLE.
//   WIDLE: s_awready=1, s_wready=0. On AW handshake, latch addr/prot/cache.
//     Next state is WLOC if awaddr==TOHOST_ADDR, else WFWD.
//   WFWD: m_awvalid from latch until m_awready (flag aw_done).
//     W passes through combinationally: m_wvalid=s_wvalid&~w_done, s_wready=m_wready&~w_done.
//     When both aw_done and w_done -> WMRSP. AW and W may complete in either order or the same cycle.
//   WMRSP: s_bvalid=m_bvalid, s_bresp=m_bresp, m_bready=s_bready.
//     On m_bvalid&s_bready -> WIDLE.
//   WLOC: s_wready=1. On W handshake, byte-merge wdata into tohost_data per wstrb; -> WLRSP.
//   WLRSP: s_bvalid=1, bresp=OKAY. On s_bready: tohost_valid pulses, done |= (tohost_data!=0),
//     then -> WIDLE. Nothing is sent downstream.
//  Read FSM: RIDLE -> RFWD | RLRSP; RFWD -> RMRSP -> RIDLE.
//   RIDLE: s_arready=1; latch araddr/prot/cache.
//   RFWD: m_arvalid until m_arready.
//   RMRSP: R channel passed through (valid/resp/data; m_rready=s_rready).
//   RLRSP: s_rvalid=1, rdata=tohost_data, rresp=OKAY.
//  Latency: forwarded AW/AR add exactly one cycle. Local B/R valid one cycle after W/AR handshake.
//  Response payloads are held stable while valid&~ready (AXI rule). No combinational valid->ready loop
//    from s_ to m_ except the W/B/R pass-throughs.
//  Simultaneous tohost write-response and tohost read: read returns the pre-write value unless the
//    W handshake occurred on an earlier cycle.
//  tohost writes of 0 update tohost_data but never set done. A later nonzero write re-evaluates pass;
//    done stays 1.
//  Reset asserted mid-transaction: immediate return to reset values. In-flight beats are dropped;
//    no response is issued.
// TESTING
//  1 Write 32'h1 to 0x6000, wstrb=F, AW and W same cycle -> B OKAY 2 cycles later; tohost_valid
//    pulse; done=1, pass=1; no m_awvalid.
//  2 Write 32'h0000_0539 to 0x6000 -> done=1, pass=0, tohost_data=0x539.
//    Read 0x6000 -> rdata=0x539.
//  3 Write 0xDEADBEEF to 0x100 with W 3 cycles before AW; m_awready held low 4 cycles ->
//    SRAM sees one AW + one W; s_bresp equals m_bresp.
//  4 Read 0x104 with s_rready low 5 cycles -> s_rdata stable and equal to SRAM data; m_rready low
//    throughout the stall.
//  5 Byte write 0xAB, wstrb=4'b0100 to 0x6000 after tohost=0 -> tohost_data=0x00AB0000, done=1.
//  6 Assert reset while in WFWD with w_done=1 -> all valids 0 the same cycle; after release,
//    a fresh write completes normally.

Source files
------------

// File: rtl/axi4lite_tohost_splitter_if.sv
// AXI4-Lite channel bundle shared by the core-facing and SRAM-facing ports of the tohost splitter.
interface axi4lite_tohost_splitter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic [3:0]        awcache;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic [3:0]        arcache;
    logic              rvalid;
    logic              rready;
    logic [1:0]        rresp;
    logic [31:0]       rdata;

    modport master (
        output awvalid, awaddr, awprot, awcache, input awready,
        output wvalid, wdata, wstrb, input wready,
        input bvalid, bresp, output bready,
        output arvalid, araddr, arprot, arcache, input arready,
        input rvalid, rresp, rdata, output rready
    );

    modport slave (
        input awvalid, awaddr, awprot, awcache, output awready,
        input wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input arvalid, araddr, arprot, arcache, output arready,
        output rvalid, rresp, rdata, input rready
    );
endinterface

// File: rtl/axi4lite_tohost_splitter.sv
// Forwards AXI4-Lite traffic from the core to the data SRAM, terminating accesses to the tohost
// word locally and exposing the latched tohost code as done/pass status.
module axi4lite_tohost_splitter #(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 'h6000,
    parameter logic [31:0]       SUCCESS_CODE = 32'd1
) (
    input  logic                              clk,
    input  logic                              rst,
    axi4lite_tohost_splitter_if.slave         s_bus,
    axi4lite_tohost_splitter_if.master        m_bus,
    output logic                              tohost_valid,
    output logic [31:0]                       tohost_data,
    output logic                              done,
    output logic                              pass
);
    typedef enum logic [2:0] {WIdle, WFwd, WMrsp, WLoc, WLrsp} wstate_e;
    typedef enum logic [1:0] {RIdle, RFwd, RMrsp, RLrsp} rstate_e;

    wstate_e           wstate_q, wstate_d;
    rstate_e           rstate_q, rstate_d;
    logic              awready_q, awready_d, arready_q, arready_d;
    logic              m_awvalid_q, m_awvalid_d, m_arvalid_q, m_arvalid_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic              lbvalid_q, lbvalid_d, lrvalid_q, lrvalid_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [2:0]        awprot_q, awprot_d, arprot_q, arprot_d;
    logic [3:0]        awcache_q, awcache_d, arcache_q, arcache_d;
    logic [31:0]       tohost_q, tohost_d, rdata_q, rdata_d;
    logic              done_q, done_d, tv_q, tv_d;

    always_comb begin
        wstate_d  = wstate_q;
        awaddr_d  = awaddr_q;
        awprot_d  = awprot_q;
        awcache_d = awcache_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        tohost_d  = tohost_q;
        done_d    = done_q;
        tv_d      = 1'b0;
        case (wstate_q)
            WIdle: begin
                if (awready_q && s_bus.awvalid) begin
                    awaddr_d  = s_bus.awaddr;
                    awprot_d  = s_bus.awprot;
                    awcache_d = s_bus.awcache;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wstate_d  = (s_bus.awaddr == TOHOST_ADDR) ? WLoc : WFwd;
                end
            end
            WFwd: begin
                if (m_awvalid_q && m_bus.awready) aw_done_d = 1'b1;
                if (s_bus.wvalid && m_bus.wready && !w_done_q) w_done_d = 1'b1;
                if (aw_done_d && w_done_d) wstate_d = WMrsp;
            end
            WMrsp: begin
                if (m_bus.bvalid && s_bus.bready) wstate_d = WIdle;
            end
            WLoc: begin
                if (s_bus.wvalid) begin
                    for (int i = 0; i < 4; i++) begin
                        if (s_bus.wstrb[i]) tohost_d[8*i +: 8] = s_bus.wdata[8*i +: 8];
                    end
                    wstate_d = WLrsp;
                end
            end
            WLrsp: begin
                if (s_bus.bready) begin
                    tv_d     = 1'b1;
                    done_d   = done_q | (tohost_q != 32'd0);
                    wstate_d = WIdle;
                end
            end
            default: wstate_d = WIdle;
        endcase
        // Handshake outputs are registered copies of the next-state decode.
        awready_d   = (wstate_d == WIdle);
        m_awvalid_d = (wstate_d == WFwd) && !aw_done_d;
        lbvalid_d   = (wstate_d == WLrsp);
    end

    always_comb begin
        rstate_d  = rstate_q;
        araddr_d  = araddr_q;
        arprot_d  = arprot_q;
        arcache_d = arcache_q;
        rdata_d   = rdata_q;
        case (rstate_q)
            RIdle: begin
                if (arready_q && s_bus.arvalid) begin
                    araddr_d  = s_bus.araddr;
                    arprot_d  = s_bus.arprot;
                    arcache_d = s_bus.arcache;
                    // Snapshot before any same-edge tohost update lands.
                    rdata_d   = tohost_q;
                    rstate_d  = (s_bus.araddr == TOHOST_ADDR) ? RLrsp : RFwd;
                end
            end
            RFwd:    if (m_arvalid_q && m_bus.arready) rstate_d = RMrsp;
            RMrsp:   if (m_bus.rvalid && s_bus.rready) rstate_d = RIdle;
            RLrsp:   if (s_bus.rready) rstate_d = RIdle;
            default: rstate_d = RIdle;
        endcase
        arready_d   = (rstate_d == RIdle);
        m_arvalid_d = (rstate_d == RFwd);
        lrvalid_d   = (rstate_d == RLrsp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q    <= WIdle;
            rstate_q    <= RIdle;
            awready_q   <= 1'b0;
            arready_q   <= 1'b0;
            m_awvalid_q <= 1'b0;
            m_arvalid_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            lbvalid_q   <= 1'b0;
            lrvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            awprot_q    <= '0;
            arprot_q    <= '0;
            awcache_q   <= '0;
            arcache_q   <= '0;
            tohost_q    <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            tv_q        <= 1'b0;
        end else begin
            wstate_q    <= wstate_d;
            rstate_q    <= rstate_d;
            awready_q   <= awready_d;
            arready_q   <= arready_d;
            m_awvalid_q <= m_awvalid_d;
            m_arvalid_q <= m_arvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            lbvalid_q   <= lbvalid_d;
            lrvalid_q   <= lrvalid_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            awprot_q    <= awprot_d;
            arprot_q    <= arprot_d;
            awcache_q   <= awcache_d;
            arcache_q   <= arcache_d;
            tohost_q    <= tohost_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            tv_q        <= tv_d;
        end
    end

    always_comb begin
        s_bus.awready = awready_q;
        m_bus.awvalid = m_awvalid_q;
        m_bus.awaddr  = awaddr_q;
        m_bus.awprot  = awprot_q;
        m_bus.awcache = awcache_q;
        m_bus.wdata   = s_bus.wdata;
        m_bus.wstrb   = s_bus.wstrb;
        m_bus.wvalid  = 1'b0;
        s_bus.wready  = 1'b0;
        s_bus.bvalid  = lbvalid_q;
        s_bus.bresp   = 2'b00;
        m_bus.bready  = 1'b0;
        case (wstate_q)
            WFwd: begin
                m_bus.wvalid = s_bus.wvalid & ~w_done_q;
                s_bus.wready = m_bus.wready & ~w_done_q;
            end
            WLoc: s_bus.wready = 1'b1;
            WMrsp: begin
                s_bus.bvalid = m_bus.bvalid;
                s_bus.bresp  = m_bus.bresp;
                m_bus.bready = s_bus.bready;
            end
            default: ;
        endcase
    end

    always_comb begin
        s_bus.arready = arready_q;
        m_bus.arvalid = m_arvalid_q;
        m_bus.araddr  = araddr_q;
        m_bus.arprot  = arprot_q;
        m_bus.arcache = arcache_q;
        s_bus.rvalid  = lrvalid_q;
        s_bus.rdata   = rdata_q;
        s_bus.rresp   = 2'b00;
        m_bus.rready  = 1'b0;
        if (rstate_q == RMrsp) begin
            s_bus.rvalid = m_bus.rvalid;
            s_bus.rdata  = m_bus.rdata;
            s_bus.rresp  = m_bus.rresp;
            m_bus.rready = s_bus.rready;
        end
    end

    assign tohost_valid = tv_q;
    assign tohost_data  = tohost_q;
    assign done         = done_q;
    assign pass         = done_q && (tohost_q == SUCCESS_CODE);
endmodule

// File: tb/tb_axi4lite_tohost_splitter.sv
// Randomized and directed bench for the tohost splitter: a core-side master, an SRAM responder and
// a transaction-level model of memory contents, tohost status and downstream beat counts.
module tb_axi4lite_tohost_splitter;
    localparam logic [31:0] TOHOST = 32'h0000_6000;

    logic        clk = 1'b0;
    logic        rst;
    logic        tohost_valid;
    logic [31:0] tohost_data;
    logic        done;
    logic        pass;

    axi4lite_tohost_splitter_if #(.ADDR_W(32)) s_if ();
    axi4lite_tohost_splitter_if #(.ADDR_W(32)) m_if ();

    axi4lite_tohost_splitter #(
        .ADDR_W      (32),
        .TOHOST_ADDR (TOHOST),
        .SUCCESS_CODE(32'd1)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .s_bus       (s_if),
        .m_bus       (m_if),
        .tohost_valid(tohost_valid),
        .tohost_data (tohost_data),
        .done        (done),
        .pass        (pass)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int m_aw_cnt = 0, m_w_cnt = 0, m_ar_cnt = 0, aw_stall = 0, tv_cnt = 0;
    int mdl_aw = 0, mdl_w = 0, mdl_ar = 0, mdl_tv = 0;
    logic [31:0] mdl_tohost = '0;
    logic        mdl_done = 1'b0;
    logic [31:0] mdl_mem [logic [31:0]];
    logic [31:0] sram    [logic [31:0]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [1:0] sram_resp(input logic [31:0] a);
        return a[2] ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
    endfunction

    always @(negedge clk) if (!rst && tohost_valid) tv_cnt <= tv_cnt + 1;

    // SRAM responder: random ready, one outstanding write and read, response one cycle later.
    initial begin : sram_model
        logic [31:0] wa, ra, wd, cur;
        logic [3:0]  ws;
        bit have_aw, have_w, have_ar, aw_f, w_f, b_f, ar_f, r_f;
        have_aw = 0; have_w = 0; have_ar = 0;
        m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = 0;
        m_if.arready = 0; m_if.rvalid = 0; m_if.rresp = 0; m_if.rdata = 0;
        forever begin
            @(negedge clk);
            aw_f = m_if.awvalid && m_if.awready;
            w_f  = m_if.wvalid && m_if.wready;
            b_f  = m_if.bvalid && m_if.bready;
            ar_f = m_if.arvalid && m_if.arready;
            r_f  = m_if.rvalid && m_if.rready;
            if (aw_f) begin wa = m_if.awaddr; have_aw = 1; m_aw_cnt++; end
            if (w_f) begin wd = m_if.wdata; ws = m_if.wstrb; have_w = 1; m_w_cnt++; end
            if (ar_f) begin ra = m_if.araddr; have_ar = 1; m_ar_cnt++; end
            @(posedge clk);
            #1;
            if (rst) begin
                have_aw = 0; have_w = 0; have_ar = 0; aw_stall = 0;
                m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0;
                m_if.arready = 0; m_if.rvalid = 0;
            end else begin
                if (b_f) m_if.bvalid = 0;
                if (r_f) m_if.rvalid = 0;
                if (have_aw && have_w && !m_if.bvalid) begin
                    cur = sram.exists(wa) ? sram[wa] : init_word(wa);
                    sram[wa] = merge(cur, wd, ws);
                    m_if.bvalid = 1; m_if.bresp = sram_resp(wa);
                    have_aw = 0; have_w = 0;
                end
                if (have_ar && !m_if.rvalid) begin
                    m_if.rvalid = 1;
                    m_if.rdata  = sram.exists(ra) ? sram[ra] : init_word(ra);
                    m_if.rresp  = sram_resp(ra);
                    have_ar = 0;
                end
                if (aw_stall > 0) begin
                    aw_stall--;
                    m_if.awready = 0;
                end else begin
                    m_if.awready = !have_aw && ($urandom_range(0, 2) != 0);
                end
                m_if.wready  = !have_w && ($urandom_range(0, 2) != 0);
                m_if.arready = !have_ar && !m_if.rvalid && ($urandom_range(0, 2) != 0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status();
        check_eq("tohost_data", tohost_data, mdl_tohost);
        check_eq("done", 32'(done), 32'(mdl_done));
        check_eq("pass", 32'(pass), 32'(mdl_done && mdl_tohost == 32'd1));
        check_eq("tohost_valid_cnt", tv_cnt, mdl_tv);
        check_eq("m_aw_cnt", m_aw_cnt, mdl_aw);
        check_eq("m_w_cnt", m_w_cnt, mdl_w);
        check_eq("m_ar_cnt", m_ar_cnt, mdl_ar);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly);
        bit aw_ok, w_ok, b_ok;
        int n, b_lat;
        logic [1:0] exp_resp;
        aw_ok = 0; w_ok = 0; b_ok = 0; n = 0; b_lat = -1;
        if (addr == TOHOST) begin
            mdl_tohost = merge(mdl_tohost, data, strb);
            exp_resp = 2'b00;
        end else begin
            mdl_mem[addr] = merge(mdl_read(addr), data, strb);
            mdl_aw++; mdl_w++;
            exp_resp = sram_resp(addr);
        end
        s_if.awaddr = addr; s_if.awprot = 3'($urandom); s_if.awcache = 4'($urandom);
        s_if.wdata = data; s_if.wstrb = strb;
        while (!b_ok && n < 100) begin
            s_if.awvalid = !aw_ok && n >= aw_dly;
            s_if.wvalid  = !w_ok && n >= w_dly;
            s_if.bready  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (s_if.awvalid && s_if.awready) aw_ok = 1;
            if (s_if.wvalid && s_if.wready) w_ok = 1;
            if (s_if.bvalid && b_lat < 0) b_lat = n;
            if (s_if.bvalid && s_if.bready) begin
                b_ok = 1;
                check_eq("bresp", 32'(s_if.bresp), 32'(exp_resp));
            end
            cyc();
            n++;
        end
        s_if.awvalid = 0; s_if.wvalid = 0; s_if.bready = 0;
        check_eq("write_completed", 32'(b_ok), 32'd1);
        if (addr == TOHOST) begin
            mdl_done = mdl_done | (mdl_tohost != 32'd0);
            mdl_tv++;
            if (aw_dly == 0 && w_dly == 0) check_eq("tohost_b_latency", b_lat, 2);
        end
        cyc();
        check_status();
    endtask

    task automatic axi_read(input logic [31:0] addr, input int stall);
        bit ar_ok, r_ok, fwd;
        int n, held;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        ar_ok = 0; r_ok = 0; n = 0; held = 0;
        fwd = (addr != TOHOST);
        if (fwd) begin
            exp_d = mdl_read(addr); exp_r = sram_resp(addr); mdl_ar++;
        end else begin
            exp_d = mdl_tohost; exp_r = 2'b00;
        end
        s_if.araddr = addr; s_if.arprot = 3'($urandom); s_if.arcache = 4'($urandom);
        while (!r_ok && n < 100) begin
            s_if.arvalid = !ar_ok;
            s_if.rready  = (held >= stall);
            @(negedge clk);
            if (s_if.arvalid && s_if.arready) ar_ok = 1;
            if (s_if.rvalid) begin
                if (s_if.rready) begin
                    r_ok = 1;
                    check_eq("rdata", s_if.rdata, exp_d);
                    check_eq("rresp", 32'(s_if.rresp), 32'(exp_r));
                end else begin
                    check_eq("rdata_stall", s_if.rdata, exp_d);
                    if (fwd) check_eq("m_rready_stall", 32'(m_if.rready), 32'd0);
                end
                held++;
            end
            cyc();
            n++;
        end
        s_if.arvalid = 0; s_if.rready = 0;
        check_eq("read_completed", 32'(r_ok), 32'd1);
        check_eq("m_ar_cnt", m_ar_cnt, mdl_ar);
    endtask

    task automatic check_all_idle(input string tag);
        check_eq(tag, {23'd0, s_if.awready, s_if.arready, s_if.bvalid, s_if.rvalid, m_if.awvalid,
                       m_if.wvalid, m_if.arvalid, tohost_valid, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] addr, data;
        int sel, n;
        bit aw_ok, w_ok;
        rst = 1'b1;
        s_if.awvalid = 0; s_if.awaddr = 0; s_if.awprot = 0; s_if.awcache = 0;
        s_if.wvalid = 0; s_if.wdata = 0; s_if.wstrb = 0; s_if.bready = 0;
        s_if.arvalid = 0; s_if.araddr = 0; s_if.arprot = 0; s_if.arcache = 0; s_if.rready = 0;
        repeat (2) @(negedge clk);
        check_all_idle("reset_outputs");
        check_eq("reset_tohost_data", tohost_data, 32'd0);
        check_eq("reset_pass", 32'(pass), 32'd0);
        cyc();
        rst = 1'b0;
        repeat (2) cyc();

        // Randomized mix of forwarded and local traffic.
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) addr = TOHOST;
            else if (sel == 3) addr = 32'h0000_6004;
            else addr = {22'd0, 8'($urandom_range(64, 127)), 2'b00};
            case ($urandom_range(0, 3))
                0: data = 32'd0;
                1: data = 32'd1;
                default: data = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1)
                axi_write(addr, data, 4'($urandom_range(1, 15)), $urandom_range(0, 3),
                          $urandom_range(0, 3));
            else
                axi_read(addr, $urandom_range(0, 2));
        end

        axi_write(TOHOST, 32'h0000_0001, 4'hF, 0, 0);
        axi_write(TOHOST, 32'h0000_0539, 4'hF, 0, 0);
        axi_read(TOHOST, 0);
        axi_write(TOHOST, 32'h0000_0000, 4'hF, 0, 0);
        axi_write(TOHOST, 32'h00AB_0000, 4'b0100, 0, 0);
        check_eq("byte_merge", tohost_data, 32'h00AB_0000);
        aw_stall = 4;
        axi_write(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 3, 0);
        axi_write(32'h0000_0104, 32'h1234_5678, 4'hF, 0, 0);
        axi_read(32'h0000_0104, 5);
        axi_read(32'h0000_0100, 0);

        // Reset while the forwarded write holds W done but AW is still stalled downstream.
        aw_stall = 40;
        s_if.awaddr = 32'h0000_0180; s_if.wdata = 32'hCAFE_F00D; s_if.wstrb = 4'hF;
        aw_ok = 0; w_ok = 0; n = 0;
        while (!w_ok && n < 30) begin
            s_if.awvalid = !aw_ok;
            s_if.wvalid  = !w_ok;
            @(negedge clk);
            if (s_if.awvalid && s_if.awready) aw_ok = 1;
            if (s_if.wvalid && s_if.wready) w_ok = 1;
            cyc();
            n++;
        end
        s_if.awvalid = 0; s_if.wvalid = 0;
        check_eq("pre_reset_w_done", 32'(w_ok), 32'd1);
        check_eq("pre_reset_m_awvalid", 32'(m_if.awvalid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_idle("mid_txn_reset");
        check_eq("mid_txn_reset_tohost", tohost_data, 32'd0);
        mdl_w++;
        mdl_tohost = '0;
        mdl_done = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (2) cyc();
        axi_write(32'h0000_0180, 32'h0BAD_CAFE, 4'hF, 0, 0);
        axi_read(32'h0000_0180, 1);
        axi_write(TOHOST, 32'h0000_0001, 4'hF, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
